// File: rtl/pid_pkg.sv
// Shared PID datapath types: error width, signed error types, the WIDTH+1 -> WIDTH
// saturating clamp and the sampler FSM state encoding.
package pid_pkg;

    localparam int WIDTH = 6;

    typedef logic signed [WIDTH-1:0] err_t;
    typedef logic signed [WIDTH:0]   wide_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam wide_t ERR_MAX = wide_t'(2 ** (WIDTH - 1) - 1);
    localparam wide_t ERR_MIN = wide_t'(-(2 ** (WIDTH - 1)));

    function automatic logic sat_hit(wide_t d);
        return (d > ERR_MAX) || (d < ERR_MIN);
    endfunction

    function automatic err_t sat_w(wide_t d);
        if (d > ERR_MAX)
            sat_w = ERR_MAX[WIDTH-1:0];
        else if (d < ERR_MIN)
            sat_w = ERR_MIN[WIDTH-1:0];
        else
            sat_w = d[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/meas_avg.sv
// Boxcar averager: ring buffer of the last 2^AVG_LOG2 enabled samples with a running sum.
// filled_o is high on the enabled edge that completes the first full window.
module meas_avg
    import pid_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_i,
    input  logic [WIDTH-1:0] meas_i,
    output logic [WIDTH-1:0] avg_o,
    output logic             filled_o
);

    localparam int N     = 1 << AVG_LOG2;
    localparam int SUM_W = WIDTH + AVG_LOG2;
    localparam logic [AVG_LOG2:0] FILL_LAST = (AVG_LOG2 + 1)'(N - 1);
    localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(N);

    logic [WIDTH-1:0]    ring_q [N];
    logic [AVG_LOG2-1:0] wr_ptr_q;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [AVG_LOG2:0]   fill_cnt_q;

    // The true sum never exceeds SUM_W bits, so modular add/subtract is exact.
    assign sum_d    = sum_q + SUM_W'(meas_i) - SUM_W'(ring_q[wr_ptr_q]);
    assign avg_o    = sum_q[SUM_W-1:AVG_LOG2];
    assign filled_o = ena_i && (fill_cnt_q == FILL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) ring_q[i] <= '0;
            wr_ptr_q   <= '0;
            sum_q      <= '0;
            fill_cnt_q <= '0;
        end else if (ena_i) begin
            ring_q[wr_ptr_q] <= meas_i;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
            sum_q            <= sum_d;
            if (fill_cnt_q != FILL_FULL) fill_cnt_q <= fill_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/error_sampler.sv
// PID error sampler: averaged measurement, periodic e/e_delta update with strobe and clamp flag.
// Optional ERRSAMP_DEADBAND_EN forces |E| <= DEADBAND to zero after the clamp.
//   state | meaning
//   FILL  | averaging window not yet full, ticks ignored
//   PRIME | window full, next tick loads e and e_prev with e_delta = 0
//   RUN   | every tick updates e, e_delta, e_prev
module error_sampler
    import pid_pkg::*;
#(
    parameter int DIV_W    = 8,
    parameter int AVG_LOG2 = 2
`ifdef ERRSAMP_DEADBAND_EN
    , parameter int DEADBAND = 1
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] setpoint,
    input  logic [WIDTH-1:0] measurement,
    input  logic [DIV_W-1:0] period,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] e_delta,
    output logic             e_valid,
    output logic             sat
);

    logic [WIDTH-1:0] avg;
    logic             fill_done;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick;
    state_t           state_q, state_d;
    err_t             e_q, e_d, e_delta_q, e_delta_d, e_prev_q, e_prev_d;
    logic             sat_q, sat_d, e_valid_q, e_valid_d;
    wide_t            diff, delta_wide;
    err_t             e_clamp, e_new;
    logic             clip_e;

    meas_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena_i    (ena),
        .meas_i   (measurement),
        .avg_o    (avg),
        .filled_o (fill_done)
    );

    assign tick = ena && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (ena) cnt_d = (cnt_q == '0) ? period : cnt_q - 1'b1;
    end

`ifdef ERRSAMP_DEADBAND_EN
    localparam err_t DB_POS = err_t'(DEADBAND);
    localparam err_t DB_NEG = err_t'(-DEADBAND);
`endif

    always_comb begin
        diff    = wide_t'({1'b0, setpoint}) - wide_t'({1'b0, avg});
        e_clamp = sat_w(diff);
        clip_e  = sat_hit(diff);
`ifdef ERRSAMP_DEADBAND_EN
        e_new   = ((e_clamp >= DB_NEG) && (e_clamp <= DB_POS)) ? '0 : e_clamp;
`else
        e_new   = e_clamp;
`endif
        delta_wide = wide_t'({e_new[WIDTH-1], e_new}) - wide_t'({e_prev_q[WIDTH-1], e_prev_q});
    end

    always_comb begin
        state_d   = state_q;
        e_d       = e_q;
        e_delta_d = e_delta_q;
        e_prev_d  = e_prev_q;
        sat_d     = sat_q;
        e_valid_d = 1'b0;
        case (state_q)
            // A tick coinciding with window completion is deliberately not used.
            FILL: if (fill_done) state_d = PRIME;
            PRIME: if (tick) begin
                e_d       = e_new;
                e_delta_d = '0;
                e_prev_d  = e_new;
                sat_d     = clip_e;
                e_valid_d = 1'b1;
                state_d   = RUN;
            end
            RUN: if (tick) begin
                e_d       = e_new;
                e_delta_d = sat_w(delta_wide);
                e_prev_d  = e_new;
                sat_d     = clip_e | sat_hit(delta_wide);
                e_valid_d = 1'b1;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            state_q   <= FILL;
            e_q       <= '0;
            e_delta_q <= '0;
            e_prev_q  <= '0;
            sat_q     <= 1'b0;
            e_valid_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            e_q       <= e_d;
            e_delta_q <= e_delta_d;
            e_prev_q  <= e_prev_d;
            sat_q     <= sat_d;
            e_valid_q <= e_valid_d;
        end
    end

    assign e       = e_q;
    assign e_delta = e_delta_q;
    assign e_valid = e_valid_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_error_sampler.sv
// Scoreboard bench for error_sampler: a behavioural model predicts each update and its cycle,
// a negedge monitor pops and compares on e_valid and checks outputs hold in between.
module tb_error_sampler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [5:0] setpoint = '0;
    logic [5:0] measurement = '0;
    logic [7:0] period = 8'd3;
    logic [5:0] e, e_delta;
    logic       e_valid, sat;

    error_sampler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .setpoint    (setpoint),
        .measurement (measurement),
        .period      (period),
        .e           (e),
        .e_delta     (e_delta),
        .e_valid     (e_valid),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e;
        int de;
        int s;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_e = 0, last_de = 0, last_s = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 31) return 31;
        if (v < -32) return -32;
        return v;
    endfunction

    // Reference model: window of the last 4 enabled samples, sample countdown, fill/prime flags.
    int hist[$];
    int m_remain, m_edges, m_prev, m_run;
    int m_avg, m_d, m_e, m_dd, m_de, m_s, m_tick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist = {0, 0, 0, 0};
            m_remain = 0;
            m_edges  = 0;
            m_prev   = 0;
            m_run    = 0;
            sbq.delete();
            last_e = 0; last_de = 0; last_s = 0;
        end else begin
            cyc++;
            if (ena) begin
                m_tick = (m_remain == 0);
                m_avg = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
                if (m_edges >= 4 && m_tick) begin
                    m_d = int'(setpoint) - m_avg;
                    m_e = clamp(m_d);
                    m_s = (m_e != m_d);
`ifdef ERRSAMP_DEADBAND_EN
                    if (m_e >= -1 && m_e <= 1) m_e = 0;
`endif
                    if (m_run == 0) m_de = 0;
                    else begin
                        m_dd = m_e - m_prev;
                        m_de = clamp(m_dd);
                        if (m_de != m_dd) m_s = 1;
                    end
                    m_run  = 1;
                    m_prev = m_e;
                    sbq.push_back('{e: m_e, de: m_de, s: m_s, cyc: cyc});
                end
                void'(hist.pop_front());
                hist.push_back(int'(measurement));
                m_remain = m_tick ? int'(period) : m_remain - 1;
                if (m_edges < 4) m_edges++;
            end
        end
    end

    exp_t got;
    always @(negedge clk) begin
        if (rst_n) begin
            if (e_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    got = sbq.pop_front();
                    chk("valid_cycle", cyc, got.cyc);
                    chk("e", int'($signed(e)), got.e);
                    chk("e_delta", int'($signed(e_delta)), got.de);
                    chk("sat", int'(sat), got.s);
                    last_e = got.e; last_de = got.de; last_s = got.s;
                end
            end else begin
                chk("hold_e", int'($signed(e)), last_e);
                chk("hold_e_delta", int'($signed(e_delta)), last_de);
                chk("hold_sat", int'(sat), last_s);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        step(3);
        chk("rst_e", int'(e), 0);
        chk("rst_e_delta", int'(e_delta), 0);
        chk("rst_valid", int'(e_valid), 0);
        chk("rst_sat", int'(sat), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        ena = 1'b1;
        period = 8'd3;
        setpoint = 6'd40;
        measurement = 6'd10;
        do_reset();
        step(20);

        setpoint = 6'd63; measurement = 6'd0;
        step(12);
        setpoint = 6'd0; measurement = 6'd63;
        step(12);

        setpoint = 6'd30; measurement = 6'd20;
        step(6);
        ena = 1'b0;
        step(10);
        ena = 1'b1;
        step(10);

        setpoint = 6'd20;
        foreach (hist[i]) ;
        measurement = 6'd8;  step(1);
        measurement = 6'd12; step(1);
        measurement = 6'd16; step(1);
        measurement = 6'd20; step(1);
        step(8);

        setpoint = 6'd20; measurement = 6'd21;
        step(12);
        setpoint = 6'd22; measurement = 6'd21;
        step(12);

        period = 8'd0;
        setpoint = 6'd50; measurement = 6'd5;
        step(6);
        setpoint = 6'd3; measurement = 6'd60;
        step(6);

        period = 8'd2;
        do_reset();
        setpoint = 6'd33; measurement = 6'd17;
        step(12);

        for (int i = 0; i < 400; i++) begin
            ena = ($urandom_range(0, 9) != 0);
            setpoint = 6'($urandom_range(0, 63));
            measurement = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) period = 8'($urandom_range(0, 5));
            step(1);
        end

        ena = 1'b0;
        step(3);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
